// File: rtl/reg_share_arb_pkg.sv
// Shared types and helpers for the reg_share_arb round-robin register arbiter.
package reg_share_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 8;
    localparam int NREQ_MAX = 8;

    typedef enum logic {IDLE, GRANT} state_t;

    // First set request bit at or after ptr, wrapping modulo n; 0 when none set.
    function automatic int rr_pick(input logic [NREQ_MAX-1:0] req, input int ptr, input int n);
        int         winner;
        logic       found;
        logic [2:0] idx;
        winner = 0;
        found  = 1'b0;
        for (int k = 0; k < NREQ_MAX; k++) begin
            idx = 3'((ptr + k) % n);
            if (k < n && !found && req[idx]) begin
                winner = int'(idx);
                found  = 1'b1;
            end
        end
        return winner;
    endfunction

endpackage

// File: rtl/reg_share_arb_if.sv
// Requester-side bus of reg_share_arb; lock exists only with REG_SHARE_ARB_LOCK_EN.
interface reg_share_arb_if #(
    parameter int NREQ = reg_share_arb_pkg::NREQ_DEF,
    parameter int W    = reg_share_arb_pkg::W_DEF
);
    localparam int IDXW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] wdata;
    logic [NREQ-1:0]   gnt;
    logic [W-1:0]      q;
    logic              q_valid;
    logic [IDXW-1:0]   owner;
    logic              busy;
`ifdef REG_SHARE_ARB_LOCK_EN
    logic [NREQ-1:0]   lock;

    modport master (output req, wdata, lock, input gnt, q, q_valid, owner, busy);
    modport slave  (input req, wdata, lock, output gnt, q, q_valid, owner, busy);
`else
    modport master (output req, wdata, input gnt, q, q_valid, owner, busy);
    modport slave  (input req, wdata, output gnt, q, q_valid, owner, busy);
`endif

endinterface

// File: rtl/reg_share_arb_rr_prio_sel.sv
// Combinational rotate-priority encoder: first active request starting at rr_ptr.
module rr_prio_sel
    import reg_share_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] rr_ptr,
    output logic [IDXW-1:0] winner,
    output logic            any_req
);

    logic [NREQ_MAX-1:0] req_ext;

    always_comb begin
        req_ext             = '0;
        req_ext[NREQ-1:0]   = req;
        winner              = IDXW'(rr_pick(req_ext, int'(rr_ptr), NREQ));
        any_req             = |req;
    end

endmodule

// File: rtl/reg_share_arb.sv
// Round-robin arbiter and write sequencer for one shared W-bit register.
// Optional per-owner burst locking is enabled with REG_SHARE_ARB_LOCK_EN.
module reg_share_arb
    import reg_share_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
`ifdef REG_SHARE_ARB_LOCK_EN
    ,
    parameter int MAX_LOCK = 4
`endif
) (
    input  logic          clk,
    input  logic          rst,
    reg_share_arb_if.slave bus
);

    localparam int IDXW = $clog2(NREQ);

    state_t          state, state_nxt;
    logic [NREQ-1:0] gnt, gnt_nxt;
    logic [W-1:0]    q, q_nxt;
    logic            q_valid, q_valid_nxt;
    logic [IDXW-1:0] owner, owner_nxt;
    logic            busy, busy_nxt;
    logic [IDXW-1:0] rr_ptr, rr_ptr_nxt;
    logic [IDXW-1:0] winner;
    logic            any_req;
    logic            hold_grant;

`ifdef REG_SHARE_ARB_LOCK_EN
    localparam int LCW = $clog2(MAX_LOCK) + 1;
    logic [LCW-1:0] lock_cnt, lock_cnt_nxt;
`endif

    rr_prio_sel #(.NREQ(NREQ), .IDXW(IDXW)) u_sel (
        .req     (bus.req),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            owner   <= '0;
            busy    <= 1'b0;
            rr_ptr  <= '0;
`ifdef REG_SHARE_ARB_LOCK_EN
            lock_cnt <= '0;
`endif
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            q       <= q_nxt;
            q_valid <= q_valid_nxt;
            owner   <= owner_nxt;
            busy    <= busy_nxt;
            rr_ptr  <= rr_ptr_nxt;
`ifdef REG_SHARE_ARB_LOCK_EN
            lock_cnt <= lock_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        q_nxt       = q;
        q_valid_nxt = q_valid;
        owner_nxt   = owner;
        busy_nxt    = busy;
        rr_ptr_nxt  = rr_ptr;
        hold_grant  = 1'b0;
`ifdef REG_SHARE_ARB_LOCK_EN
        lock_cnt_nxt = lock_cnt;
        hold_grant   = bus.lock[owner] && (lock_cnt < LCW'(MAX_LOCK - 1));
`endif
        unique case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (any_req) begin
                    gnt_nxt[winner] = 1'b1;
                    owner_nxt       = winner;
                    busy_nxt        = 1'b1;
                    state_nxt       = GRANT;
                end
            end
            GRANT: begin
                q_nxt       = bus.wdata[int'(owner)*W +: W];
                q_valid_nxt = 1'b1;
                // A locked owner keeps the grant and writes again next cycle.
                if (hold_grant) begin
`ifdef REG_SHARE_ARB_LOCK_EN
                    lock_cnt_nxt = lock_cnt + 1'b1;
`endif
                end else begin
                    rr_ptr_nxt = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
                    gnt_nxt    = '0;
                    busy_nxt   = 1'b0;
                    state_nxt  = IDLE;
`ifdef REG_SHARE_ARB_LOCK_EN
                    lock_cnt_nxt = '0;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.gnt     = gnt;
    assign bus.q       = q;
    assign bus.q_valid = q_valid;
    assign bus.owner   = owner;
    assign bus.busy    = busy;

endmodule

// File: doc/reg_share_arb.md
Name: reg_share_arb

Overview:
- Round-robin arbiter and write sequencer for one shared W-bit D-flip-flop register.
- NREQ requesters compete for write access. The block grants one requester at a time and loads that requester's data into the shared register.
- It exposes the register value, a valid flag and the current owner index.
- It sits between multiple producer blocks and a single storage register built from D flip-flops.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 8, shared register data width
- IDXW, $clog2(NREQ), owner index width (derived; do not override)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester write request; level, held until granted
- wdata  input  NREQ*W  packed write data; requester i at bits [i*W +: W]
- gnt  output  NREQ  one-hot registered grant
- q  output  W  shared register contents
- q_valid  output  1  high once any write has completed since reset
- owner  output  IDXW  index of last or current grantee
- busy  output  1  high while in GRANT state

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high, sampled on rising edge of clk.
- Reset values: gnt=0, q=0, q_valid=0, owner=0, busy=0, state=IDLE, rr_ptr=0.
- The round-robin pointer rr_ptr is the search start index.
- The FSM has two states, IDLE and GRANT.
- IDLE:
  - If any req bit is set, select the first set bit searching rr_ptr, rr_ptr+1, ... with modulo NREQ wrap.
  - On the next edge: gnt<=onehot(winner), owner<=winner, busy<=1, state<=GRANT.
  - If no req bit is set, stay in IDLE and keep gnt=0.
- GRANT:
  - The requester must present stable wdata during the cycle gnt is high.
  - On the closing edge: q<=wdata[owner], q_valid<=1, rr_ptr<=(owner+1) mod NREQ, gnt<=0, busy<=0, state<=IDLE.
- Timing:
  - Latency from req sampled to gnt high is 1 cycle.
  - Latency from gnt high to q updated is 1 cycle.
  - Maximum throughput is one write per 2 cycles.
- Fairness: after granting i, i has lowest priority at the next arbitration. No requester waits more than NREQ grants.
- Request release: the requester drops req in the cycle gnt is high. A req still high in the IDLE cycle after GRANT is treated as a new request, at lowest priority.
- Simultaneous requests: resolved purely by rr_ptr order.
- A req bit that falls while not granted is dropped silently, with no grant.
- A req bit that falls during its own GRANT cycle does not abort the write; the write completes.
- If rst is asserted in GRANT, the write is aborted and all reset values apply on that edge.
- q holds its value indefinitely in IDLE; wdata of non-granted requesters is ignored.
- NREQ=1 is not supported.

Optional Feature:
- Macro: REG_SHARE_ARB_LOCK_EN.
- When defined:
  - Adds input lock[NREQ] and parameter MAX_LOCK (default 4).
  - If lock[owner] is high on the GRANT closing edge and lock_cnt<MAX_LOCK-1, then: write q, stay in GRANT, keep gnt and owner, lock_cnt++.
  - This gives back-to-back writes, one per cycle.
  - When lock drops or lock_cnt reaches MAX_LOCK-1, perform the normal exit to IDLE and clear lock_cnt.
  - Reset clears lock_cnt.
- When undefined: no lock port, and behaviour is exactly as above.

Decomposition:
- Package reg_share_arb_pkg holds:
  - state enum {IDLE, GRANT}
  - function rr_pick(req, ptr) that returns the winner index
  - localparam defaults NREQ_DEF=4, W_DEF=8
- One sub-module, rr_prio_sel: a combinational rotate-priority encoder (req, rr_ptr -> winner index and any_req).
- The FSM, the data register and the lock counter stay in the top level.

Test Plan:
- Reset: hold rst=1 for 2 cycles, with req=4'b1111 -> gnt=0, q=0, q_valid=0, busy=0 throughout.
- Single requester: req=4'b0100, wdata[2]=8'hA5 -> gnt=4'b0100 one cycle later, then q=8'hA5, q_valid=1, owner=2, rr_ptr=3.
- Fairness: hold req=4'b1111 continuously with distinct data per requester. Expected grant order 0,1,2,3,0 with one grant every 2 cycles; q follows each grantee's wdata.
- Wrap and skip: rr_ptr=3 with req=4'b0011 -> requester 0 granted, then requester 1.
- Reset mid-GRANT: assert rst in the cycle gnt=4'b0010 -> next cycle q=0, gnt=0, state=IDLE, no write occurs.
- Lock (macro defined, MAX_LOCK=4): lock[1]=1 held with req[1] -> gnt[1] high for 4 consecutive cycles with 4 writes, then released. A pending req[2] is granted next.
